// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the main-memory arbiter: FSM encodings, grant IDs,
// default widths and the round-robin pick function.
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_BUSY_I = 2'd1;
  localparam logic [1:0] ARB_BUSY_D = 2'd2;
  localparam logic [1:0] ARB_DONE   = 2'd3;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINE_WIDTH_DEF = 128;
  localparam int LAT_MAX_DEF    = 15;

  // Two-way round-robin pick: a lone requester wins outright, and under
  // contention the requester that was not served last wins.
  function automatic logic rr_pick(input logic req_i, input logic req_d,
                                   input logic last_grant);
    logic pick;
    if (req_i && req_d) pick = ~last_grant;
    else if (req_d)     pick = GNT_D;
    else                pick = GNT_I;
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic. Owns the last_grant register, which only
// advances when the parent FSM actually accepts the grant.
module mem_arbiter_rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic grant_en,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_grant_q;
  logic last_grant_d;

  // Combinational grant decision and next value of last_grant.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (which would infer a latch).
    gnt_valid    = req_i | req_d;
    gnt_id       = rr_pick(req_i, req_d, last_grant_q);
    last_grant_d = last_grant_q;
    if (grant_en && gnt_valid) last_grant_d = gnt_id;
  end

  // last_grant register; resets to I so the first contended grant goes to D.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) last_grant_q <= GNT_I;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the I-cache refill path and the
// D-cache refill/writeback path. One line transaction at a time, round-robin
// under contention, with per-requester done pulses and a sticky timeout flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int LAT_MAX    = LAT_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_done,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  timeout
);

  localparam int CNT_W = $clog2(LAT_MAX + 1);

  logic [1:0]            state_q,     state_d;
  logic                  mem_req_q,   mem_req_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q,   i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q,   d_rdata_d;
  logic                  i_done_q,    i_done_d;
  logic                  d_done_q,    d_done_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  timeout_q,   timeout_d;

  logic grant_en;
  logic gnt_valid;
  logic gnt_id;

  mem_arbiter_rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (i_req),
    .req_d     (d_req),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // FSM next-state, datapath capture, wait counter and timeout.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    grant_en    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          grant_en  = 1'b1;
          mem_req_d = 1'b1;
          if (gnt_id == GNT_D) begin
            state_d     = ARB_BUSY_D;
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = ARB_BUSY_I;
            mem_addr_d  = i_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
          end
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ready) begin
          state_d = ARB_DONE;
          if (state_q == ARB_BUSY_I) begin
            i_rdata_d = mem_rdata;
            i_done_d  = 1'b1;
          end else begin
            // Writebacks leave the last refill line in d_rdata untouched.
            if (!mem_we_q) d_rdata_d = mem_rdata;
            d_done_d = 1'b1;
          end
        end else begin
          if (cnt_q != CNT_W'(LAT_MAX)) cnt_d = cnt_q + CNT_W'(1);
          // The LAT_MAX-th cycle without mem_ready flags the error; keep waiting.
          if (cnt_q >= CNT_W'(LAT_MAX - 1)) timeout_d = 1'b1;
        end
      end
      ARB_DONE: begin
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int LW      = 128;
  localparam int LAT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [LW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic          d_done;
  logic [LW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;
  logic          timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side expectations for the sticky/held outputs.
  logic [LW-1:0] m_i_rdata;
  logic [LW-1:0] m_d_rdata;
  logic          m_timeout;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LAT_MAX(LAT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serve one memory transaction: wait for mem_req (bounded), check the
  // request fields, hold mem_ready low for 'delay' cycles while checking the
  // fields stay put, complete it with 'line', then check the done pulse.
  // exp_gap < 0 skips the cycles-to-mem_req check.
  task automatic run_txn(input string tag, input logic exp_d, input logic exp_we,
                         input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata,
                         input int delay, input logic [LW-1:0] line,
                         input int exp_gap, input logic keep);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/mem_req"}, LW'(mem_req), LW'(1'b1));
    if (exp_gap >= 0) check({tag, "/gap"}, LW'(n), LW'(exp_gap));
    check({tag, "/mem_addr"},  LW'(mem_addr), LW'(exp_addr));
    check({tag, "/mem_we"},    LW'(mem_we),   LW'(exp_we));
    check({tag, "/mem_wdata"}, mem_wdata,     exp_wdata);
    for (int k = 1; k <= delay; k++) begin
      @(negedge clk);
      m_timeout = m_timeout | (k >= LAT_MAX);
      check({tag, "/req_once"},  LW'(mem_req),  LW'(1'b0));
      check({tag, "/hold_addr"}, LW'(mem_addr), LW'(exp_addr));
      check({tag, "/hold_we"},   LW'(mem_we),   LW'(exp_we));
      check({tag, "/hold_wd"},   mem_wdata,     exp_wdata);
      check({tag, "/timeout"},   LW'(timeout),  LW'(m_timeout));
    end
    mem_ready = 1'b1;
    mem_rdata = line;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (!exp_we) begin
      if (exp_d) m_d_rdata = line;
      else       m_i_rdata = line;
    end
    check({tag, "/i_done"},  LW'(i_done),  LW'(!exp_d));
    check({tag, "/d_done"},  LW'(d_done),  LW'(exp_d));
    check({tag, "/i_rdata"}, i_rdata,      m_i_rdata);
    check({tag, "/d_rdata"}, d_rdata,      m_d_rdata);
    check({tag, "/to_done"}, LW'(timeout), LW'(m_timeout));
    if (!keep) begin
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/mem_req"},   LW'(mem_req),   '0);
    check({tag, "/mem_we"},    LW'(mem_we),    '0);
    check({tag, "/mem_addr"},  LW'(mem_addr),  '0);
    check({tag, "/mem_wdata"}, mem_wdata,      '0);
    check({tag, "/i_done"},    LW'(i_done),    '0);
    check({tag, "/d_done"},    LW'(d_done),    '0);
    check({tag, "/i_rdata"},   i_rdata,        '0);
    check({tag, "/d_rdata"},   d_rdata,        '0);
    check({tag, "/timeout"},   LW'(timeout),   '0);
  endtask

  initial begin
    int req_seen;
    int n;
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    m_i_rdata = '0;
    m_d_rdata = '0;
    m_timeout = 1'b0;

    // Reset and idle: nothing moves for 20 cycles.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    req_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    check("idle/mem_req_count", LW'(req_seen), '0);
    check_all_zero("idle");

    // mem_ready while idle is ignored.
    mem_ready = 1'b1;
    mem_rdata = {4{32'h1234_5678}};
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check_all_zero("stray_ready");

    // Contention straight after reset: D first, then strict alternation with
    // one idle cycle between each done and the next mem_req.
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    run_txn("cont_d1", 1'b1, 1'b0, 32'h200, '0, 1, {4{32'hD1D1_0001}}, 1, 1'b1);
    run_txn("cont_i1", 1'b0, 1'b0, 32'h100, '0, 0, {4{32'h1111_0001}}, 2, 1'b1);
    run_txn("cont_d2", 1'b1, 1'b0, 32'h200, '0, 2, {4{32'hD2D2_0002}}, 2, 1'b1);
    run_txn("cont_i2", 1'b0, 1'b0, 32'h100, '0, 0, {4{32'h2222_0002}}, 2, 1'b1);
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) @(negedge clk);

    // Single I read at 0x40, line returned 4 cycles after mem_req.
    i_addr = 32'h0000_0040;
    i_req  = 1'b1;
    run_txn("i_read", 1'b0, 1'b0, 32'h40, '0, 4,
            128'hDEADBEEF_00000000_00000000_00000001, 1, 1'b0);
    @(negedge clk);
    check("i_read/done_pulse", LW'(i_done),  '0);
    check("i_read/no_d_done",  LW'(d_done),  '0);
    check("i_read/no_req",     LW'(mem_req), '0);
    repeat (2) @(negedge clk);

    // D writeback: fields held until mem_ready, d_rdata untouched.
    d_we    = 1'b1;
    d_addr  = 32'h0000_1000;
    d_wdata = {16{8'hA5}};
    d_req   = 1'b1;
    run_txn("d_wb", 1'b1, 1'b1, 32'h1000, {16{8'hA5}}, 3, {4{32'hBAD0_BAD0}}, 1, 1'b0);
    d_we    = 1'b0;
    d_wdata = '0;
    repeat (2) @(negedge clk);

    // Timeout: mem_ready held off for LAT_MAX+2 cycles, flag stays sticky.
    d_addr = 32'h0000_3000;
    d_req  = 1'b1;
    run_txn("timeout", 1'b1, 1'b0, 32'h3000, '0, LAT_MAX + 2, {4{32'h7777_0003}}, 1, 1'b0);
    repeat (2) @(negedge clk);
    i_addr = 32'h0000_0500;
    i_req  = 1'b1;
    run_txn("after_to", 1'b0, 1'b0, 32'h500, '0, 0, {4{32'h3333_0005}}, 1, 1'b0);
    @(negedge clk);
    check("after_to/sticky", LW'(timeout), LW'(1'b1));

    // Reset in the middle of a D read: everything clears at once, no done.
    d_addr = 32'h0000_2000;
    d_req  = 1'b1;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid/mem_req", LW'(mem_req), LW'(1'b1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    m_i_rdata = '0;
    m_d_rdata = '0;
    m_timeout = 1'b0;
    check_all_zero("rst_mid");
    d_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = {4{32'hEEEE_EEEE}};
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("rst_mid/no_d_done", LW'(d_done), '0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/post_done", LW'(d_done), '0);

    // A fresh I request after reset is granted normally.
    i_addr = 32'h0000_0080;
    i_req  = 1'b1;
    run_txn("post_rst", 1'b0, 1'b0, 32'h80, '0, 1, {4{32'h8080_0008}}, 1, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path (fetch stage) and the data-cache refill/writeback path (memory stage).
- Serialises line transactions and arbitrates round-robin between the two requesters.
- Returns read lines and per-requester completion pulses, which drive the existing fetch stall and dCacheStall hazard inputs.
- Sits between both caches and the main-memory model.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
LINE_WIDTH, 128, cache-line data width in bits
LAT_MAX, 15, cycles without mem_ready in BUSY before a timeout error is flagged

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i_req  input  1  I-cache line-read request, level, held until i_done
i_addr  input  ADDR_WIDTH  I-cache line address, stable while i_req high
i_done  output  1  one-cycle pulse, I transaction complete, i_rdata valid
i_rdata  output  LINE_WIDTH  line returned to I-cache
d_req  input  1  D-cache request, level, held until d_done
d_we  input  1  1 = line writeback, 0 = line refill read
d_addr  input  ADDR_WIDTH  D-cache line address
d_wdata  input  LINE_WIDTH  writeback line data
d_done  output  1  one-cycle pulse, D transaction complete
d_rdata  output  LINE_WIDTH  line returned to D-cache (valid with d_done when d_we=0)
mem_req  output  1  transaction start to memory, one-cycle pulse
mem_we  output  1  write strobe qualifying mem_req
mem_addr  output  ADDR_WIDTH  address to memory, held for the whole transaction
mem_wdata  output  LINE_WIDTH  write data to memory, held for the whole transaction
mem_ready  input  1  memory completion pulse; mem_rdata valid the same cycle
mem_rdata  input  LINE_WIDTH  read line from memory
timeout  output  1  sticky error flag, cleared only by rst

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, last_grant=I.
  - All outputs 0; i_rdata and d_rdata are 0.
  - Wait counter is 0.
- States:
  - IDLE: arbitrate.
  - BUSY_I: I-cache transaction outstanding.
  - BUSY_D: D-cache transaction outstanding.
  - DONE: one-cycle completion, returns to IDLE.
- IDLE arbitration, evaluated every cycle:
  - Only i_req high -> grant I.
  - Only d_req high -> grant D.
  - Both high -> grant the requester opposite last_grant. After reset the first contended grant therefore goes to D.
- On grant:
  - Register address, we and wdata into the mem_* outputs.
  - Pulse mem_req for exactly one cycle, the first cycle of BUSY_x.
  - Update last_grant.
  - I grants always drive mem_we=0.
- BUSY_x:
  - Hold mem_addr, mem_we and mem_wdata.
  - Increment the saturating wait counter each cycle.
  - On mem_ready: capture mem_rdata into the granted requester's rdata register (reads only) and go to DONE.
- DONE:
  - Pulse the granted requester's x_done for one cycle.
  - Clear the wait counter and return to IDLE.
- Latency:
  - Grant cycle = first cycle in IDLE with req high.
  - mem_req is asserted the following cycle.
  - x_done asserts one cycle after mem_ready.
  - Minimum request-to-done: 3 cycles, with mem_ready arriving in the same cycle as mem_req.
- Back-to-back: IDLE is revisited after every DONE, so there is a one-cycle minimum gap between a done and the next mem_req.
  - A requester still asserting req in the cycle after its done is treated as a new request.
  - Under contention, a requester that was just served loses to the other.
- x_rdata holds its last captured value until the next read completion for that requester. Writebacks do not modify d_rdata.
- mem_ready outside BUSY is ignored.
- mem_ready in the same cycle as mem_req is legal and completes the transaction.
- Request dropped mid-transaction: this is a protocol violation. The transaction still completes and done still pulses.
- Timeout: wait counter reaching LAT_MAX in BUSY sets timeout, which is sticky. The FSM keeps waiting for mem_ready and does not abort.
- Reset asserted mid-transaction: immediate return to the reset state. No done pulse. The outstanding memory access is abandoned.

Decomposition:
- Shared constants package (constants.v):
  - state encodings ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_DONE;
  - grant IDs GNT_I=0, GNT_D=1;
  - default LINE_WIDTH.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant logic with the last_grant register.
- FSM, datapath registers and wait counter stay in mem_arbiter.

Test Plan:
- Reset/idle: release rst with no requests -> all outputs 0, mem_req never pulses over 20 cycles.
- Single I read: i_req=1, i_addr=0x40, memory returns 0xDEADBEEF_..._0001 after 4 cycles -> exactly one mem_req with mem_we=0 and mem_addr=0x40; i_done pulses once with i_rdata equal to the returned line; d_done stays 0.
- Contention: i_req and d_req asserted in the same cycle after reset -> D served first, then I. Re-asserting both immediately -> order D, I, D, I alternating; one idle cycle between each done and the next mem_req.
- D writeback: d_we=1, d_addr=0x1000, d_wdata=0xA5 pattern -> mem_we=1 and mem_wdata held stable until mem_ready; d_done pulses; d_rdata unchanged from its prior value.
- Timeout: hold mem_ready low for LAT_MAX+2 cycles -> timeout rises at cycle LAT_MAX and stays high after a later mem_ready completes the transaction; only rst clears it.
- Reset mid-transaction: assert rst during BUSY_D -> outputs 0 immediately with no d_done. A new i_req after reset is granted normally.
